demux4x32_buf: RTL

- 32-bit one-to-four buffered demultiplexer; the distributing counterpart to the datapath's 4-way selectors.
- Accepts one word per cycle on a valid/ready input and steers it, by 2-bit select s, into one of four per-lane FIFOs.
- Each lane drains independently through its own valid/ready output.
- Sits between a single producer (e.g. writeback/result bus) and four consumers (register-file banks, peripheral ports).

---
 rtl/demux4x32_pkg.sv | 23 ++
 rtl/lane_fifo.sv | 74 +++++++
 rtl/demux4x32_buf.sv | 86 ++++++++
 3 files changed

// File: rtl/demux4x32_pkg.sv
// Shared constants and helpers for the 1-to-4 buffered demultiplexer (demux4x32_buf).
package demux4x32_pkg;

    localparam logic [1:0] LANE0 = 2'b00;
    localparam logic [1:0] LANE1 = 2'b01;
    localparam logic [1:0] LANE2 = 2'b10;
    localparam logic [1:0] LANE3 = 2'b11;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned DEF_DEPTH = 2;
    localparam int unsigned DEF_WIDTH = 32;

    // Ceiling log2 for constant pointer/count width computation; n >= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// Single-lane synchronous FIFO: registered head output, full/valid flags from the occupancy count.
module lane_fifo
    import demux4x32_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    localparam int unsigned PtrW = clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CntW'(DEPTH));
    assign valid = (count_q != '0);
    assign dout  = mem_q[rd_ptr_q];

    // A full lane refuses the push even when it pops in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/demux4x32_buf.sv
// 32-bit one-to-four buffered demultiplexer; steers each accepted word into one of four lane FIFOs.
// Optional broadcast input enabled by defining DEMUX4X32_BCAST_EN.
module demux4x32_buf
    import demux4x32_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       s,
    input  logic             in_valid,
`ifdef DEMUX4X32_BCAST_EN
    input  logic             bcast,
`endif
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             v0,
    output logic             v1,
    output logic             v2,
    output logic             v3,
    input  logic             r0,
    input  logic             r1,
    input  logic             r2,
    input  logic             r3
);

    logic [NUM_LANES-1:0] sel;
    logic [NUM_LANES-1:0] lane_full;
    logic [NUM_LANES-1:0] lane_valid;
    logic [NUM_LANES-1:0] lane_push;
    logic [NUM_LANES-1:0] lane_pop;
    logic [WIDTH-1:0]     lane_dout [NUM_LANES];
    logic                 accept;

    always_comb begin
        sel = '0;
        unique case (s)
            LANE0: sel[0] = 1'b1;
            LANE1: sel[1] = 1'b1;
            LANE2: sel[2] = 1'b1;
            LANE3: sel[3] = 1'b1;
        endcase
`ifdef DEMUX4X32_BCAST_EN
        if (bcast) begin
            sel = '1;
        end
`endif
    end

    // Ready looks only at registered fullness and the select, never at consumer readies.
    assign in_ready  = ~|(sel & lane_full);
    assign accept    = in_valid & in_ready;
    assign lane_push = sel & {NUM_LANES{accept}};
    assign lane_pop  = {r3, r2, r1, r0};

    for (genvar i = 0; i < int'(NUM_LANES); i++) begin : g_lane
        lane_fifo #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) u_lane_fifo (
            .clk  (clk),
            .rst  (rst),
            .push (lane_push[i]),
            .din  (a),
            .pop  (lane_pop[i]),
            .dout (lane_dout[i]),
            .valid(lane_valid[i]),
            .full (lane_full[i])
        );
    end

    assign y0 = lane_dout[0];
    assign y1 = lane_dout[1];
    assign y2 = lane_dout[2];
    assign y3 = lane_dout[3];
    assign v0 = lane_valid[0];
    assign v1 = lane_valid[1];
    assign v2 = lane_valid[2];
    assign v3 = lane_valid[3];

endmodule
